// File: rtl/ss_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package ss_pkg;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] CODE_DASH = 4'hA;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [3:0] an_for(digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/ss_scan4_if.sv
// Load handshake and display pin bundle for ss_scan4.
// master = producer of digit data (and observer of the pins), slave = the scanner.
interface ss_scan4_if;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        pending;
    logic        frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output load, digits_in, dp_in,
        input  pending, frame_done, an, seg, dp
    );

    modport slave (
        input  load, digits_in, dp_in,
        output pending, frame_done, an, seg, dp
    );
endinterface

// File: rtl/ss_dec7.sv
// Combinational nibble to seven-segment decoder (active low).
// blank overrides the code and turns every segment off.
module ss_dec7
    import ss_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            unique case (code)
                4'h0:      seg = SEG_0;
                4'h1:      seg = SEG_1;
                4'h2:      seg = SEG_2;
                4'h3:      seg = SEG_3;
                4'h4:      seg = SEG_4;
                4'h5:      seg = SEG_5;
                4'h6:      seg = SEG_6;
                4'h7:      seg = SEG_7;
                4'h8:      seg = SEG_8;
                4'h9:      seg = SEG_9;
                CODE_DASH: seg = SEG_DASH;
                default:   seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/ss_scan4.sv
// Four-digit common-anode scanner with a shadow/display double buffer.
// Optional leading-zero blanking is enabled by defining SS_LZ_BLANK_EN.
module ss_scan4
    import ss_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
)(
    input  logic     clk,
    input  logic     rst,
    ss_scan4_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] prescaler;
    digit_idx_t       idx;
    logic             tick;
    logic             frame;

    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic [3:0]       shadow_dp;
    logic [3:0]       disp_dp;
    logic             pending_q;
    logic             frame_done_q;

    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             lz_blank;
    logic [6:0]       dec_seg;

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    assign tick  = (prescaler == DIV_LAST);
    assign frame = tick && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                idx       <= idx + 2'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // The boundary commits whatever the shadow held before this edge; a load
    // in the same cycle refills the shadow and keeps pending set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            shadow_dp    <= '0;
            disp         <= '0;
            disp_dp      <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame;
            if (frame && pending_q) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
            end
            if (bus.load) begin
                shadow    <= bus.digits_in;
                shadow_dp <= bus.dp_in;
                pending_q <= 1'b1;
            end else if (frame) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib = disp[3:0];
        cur_dp  = disp_dp[0];
        unique case (idx)
            2'd0: begin cur_nib = disp[3:0];   cur_dp = disp_dp[0]; end
            2'd1: begin cur_nib = disp[7:4];   cur_dp = disp_dp[1]; end
            2'd2: begin cur_nib = disp[11:8];  cur_dp = disp_dp[2]; end
            2'd3: begin cur_nib = disp[15:12]; cur_dp = disp_dp[3]; end
            default: ;
        endcase
    end

`ifdef SS_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 1'b0;
        unique case (idx)
            2'd1:    lz_blank = (disp[15:4]  == 12'h000);
            2'd2:    lz_blank = (disp[15:8]  == 8'h00);
            2'd3:    lz_blank = (disp[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    ss_dec7 u_dec7 (
        .code  (cur_nib),
        .blank (lz_blank),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_for(idx);
            seg_q <= dec_seg;
            dp_q  <= ~cur_dp;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;

endmodule
